// File: rtl/range_scan_ctrl.sv
// range_scan_ctrl: walks a shared address across every low/high bound bank
// pair in parallel and reports whether the latched query ID falls inside any
// stored inclusive range. It also keeps a saturating count of hit results.
module range_scan_ctrl #(
  parameter int NUM_BANKS   = 4,
  parameter int MEM_LENGTH  = 64,
  parameter int SHORT_INDEX = -1,
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 64,
  parameter int COUNT_WIDTH = 16,
  parameter int EARLY_EXIT  = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            id_valid,
  output logic                            id_ready,
  input  logic [DATA_WIDTH-1:0]           id_data,
  output logic [ADDR_WIDTH-1:0]           bank_addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] low_dout,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] high_dout,
  output logic                            result_valid,
  input  logic                            result_ready,
  output logic                            result_hit,
  input  logic                            count_clear,
  output logic [COUNT_WIDTH-1:0]          hit_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(MEM_LENGTH - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = ADDR_WIDTH'(1);

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   idLatch_q;
  logic                    hitAcc_q;
  logic [ADDR_WIDTH-1:0]   bankAddr_q;
  logic                    resultValid_q;
  logic                    resultHit_q;
  logic [COUNT_WIDTH-1:0]  hitCount_q;
  logic [COUNT_WIDTH-1:0]  hitCount_d;

  logic [NUM_BANKS-1:0]    bankHit;
  logic                    hitNow;
  logic                    scanStop;
  logic                    finalHit;

  // Per-bank match at the current address. Banks from the short index onward
  // lack their last entry, so whatever they return at that address is ignored.
  for (genvar g = 0; g < NUM_BANKS; g++) begin : gBank
    localparam logic [31:0] BANK_DEPTH =
      ((SHORT_INDEX >= 0) && (g >= SHORT_INDEX)) ? 32'(MEM_LENGTH - 1) : 32'(MEM_LENGTH);
    logic [DATA_WIDTH-1:0] lowVal;
    logic [DATA_WIDTH-1:0] highVal;
    logic                  addrInBank;
    assign lowVal     = low_dout[g*DATA_WIDTH +: DATA_WIDTH];
    assign highVal    = high_dout[g*DATA_WIDTH +: DATA_WIDTH];
    assign addrInBank = (32'(bankAddr_q) < BANK_DEPTH);
    assign bankHit[g] = addrInBank && (lowVal <= idLatch_q) && (idLatch_q <= highVal);
  end

  assign hitNow = |bankHit;

  // Decide when the sweep ends, what the final verdict is, and the next
  // counter value. A clear arriving with an increment leaves exactly one hit.
  always_comb begin
    scanStop   = 1'b0;
    finalHit   = hitAcc_q | hitNow;
    hitCount_d = hitCount_q;
    if (state_q == SCAN) begin
      scanStop = (bankAddr_q == LAST_ADDR) || ((EARLY_EXIT != 0) && hitNow);
    end
    if (scanStop && finalHit && (hitCount_q != '1)) begin
      hitCount_d = hitCount_q + COUNT_ONE;
    end
    if (count_clear) begin
      hitCount_d = (scanStop && finalHit) ? COUNT_ONE : '0;
    end
  end

  // Control FSM with all outputs registered; reset discards any in-flight
  // query without counting it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idLatch_q     <= '0;
      hitAcc_q      <= 1'b0;
      bankAddr_q    <= '0;
      resultValid_q <= 1'b0;
      resultHit_q   <= 1'b0;
      hitCount_q    <= '0;
    end else begin
      hitCount_q <= hitCount_d;
      unique case (state_q)
        IDLE: begin
          if (id_valid) begin
            idLatch_q  <= id_data;
            hitAcc_q   <= 1'b0;
            bankAddr_q <= '0;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          hitAcc_q <= finalHit;
          if (scanStop) begin
            state_q       <= DONE;
            resultValid_q <= 1'b1;
            resultHit_q   <= finalHit;
            bankAddr_q    <= '0;
          end else begin
            bankAddr_q <= bankAddr_q + ADDR_ONE;
          end
        end
        DONE: begin
          if (result_ready) begin
            resultValid_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign id_ready     = rst_n && (state_q == IDLE);
  assign bank_addr    = bankAddr_q;
  assign result_valid = resultValid_q;
  assign result_hit   = resultHit_q;
  assign hit_count    = hitCount_q;

endmodule

// File: tb/tb_range_scan_ctrl.sv
// tb_range_scan_ctrl: four range_scan_ctrl instances with different
// configurations share one clock, reset and pair of bound ROM tables. Each
// query is predicted by a reference model that searches the tables directly.
module tb_range_scan_ctrl;

  // Instance 0: short bank 1, full sweep. Instance 1: no short banks.
  // Instance 2: early exit. Instance 3: two-bit hit counter.
  logic        clk;
  logic        rst_n;
  logic        idValid     [4];
  logic        idReady     [4];
  logic [15:0] idData      [4];
  logic [1:0]  bankAddr    [4];
  logic [31:0] lowDout     [4];
  logic [31:0] highDout    [4];
  logic        resultValid [4];
  logic        resultReady [4];
  logic        resultHit   [4];
  logic        countClear  [4];
  logic [15:0] hitCountW   [3];
  logic [1:0]  hitCountN;

  logic [15:0] lowRom  [2][4];
  logic [15:0] highRom [2][4];

  int checks;
  int failures;
  int modelCount [4];

  range_scan_ctrl #(.NUM_BANKS(2), .MEM_LENGTH(4), .SHORT_INDEX(1), .ADDR_WIDTH(2),
                    .DATA_WIDTH(16), .COUNT_WIDTH(16), .EARLY_EXIT(0)) dutA (
    .clk(clk), .rst_n(rst_n), .id_valid(idValid[0]), .id_ready(idReady[0]),
    .id_data(idData[0]), .bank_addr(bankAddr[0]), .low_dout(lowDout[0]),
    .high_dout(highDout[0]), .result_valid(resultValid[0]), .result_ready(resultReady[0]),
    .result_hit(resultHit[0]), .count_clear(countClear[0]), .hit_count(hitCountW[0]));

  range_scan_ctrl #(.NUM_BANKS(2), .MEM_LENGTH(4), .SHORT_INDEX(-1), .ADDR_WIDTH(2),
                    .DATA_WIDTH(16), .COUNT_WIDTH(16), .EARLY_EXIT(0)) dutB (
    .clk(clk), .rst_n(rst_n), .id_valid(idValid[1]), .id_ready(idReady[1]),
    .id_data(idData[1]), .bank_addr(bankAddr[1]), .low_dout(lowDout[1]),
    .high_dout(highDout[1]), .result_valid(resultValid[1]), .result_ready(resultReady[1]),
    .result_hit(resultHit[1]), .count_clear(countClear[1]), .hit_count(hitCountW[1]));

  range_scan_ctrl #(.NUM_BANKS(2), .MEM_LENGTH(4), .SHORT_INDEX(1), .ADDR_WIDTH(2),
                    .DATA_WIDTH(16), .COUNT_WIDTH(16), .EARLY_EXIT(1)) dutC (
    .clk(clk), .rst_n(rst_n), .id_valid(idValid[2]), .id_ready(idReady[2]),
    .id_data(idData[2]), .bank_addr(bankAddr[2]), .low_dout(lowDout[2]),
    .high_dout(highDout[2]), .result_valid(resultValid[2]), .result_ready(resultReady[2]),
    .result_hit(resultHit[2]), .count_clear(countClear[2]), .hit_count(hitCountW[2]));

  range_scan_ctrl #(.NUM_BANKS(2), .MEM_LENGTH(4), .SHORT_INDEX(1), .ADDR_WIDTH(2),
                    .DATA_WIDTH(16), .COUNT_WIDTH(2), .EARLY_EXIT(0)) dutD (
    .clk(clk), .rst_n(rst_n), .id_valid(idValid[3]), .id_ready(idReady[3]),
    .id_data(idData[3]), .bank_addr(bankAddr[3]), .low_dout(lowDout[3]),
    .high_dout(highDout[3]), .result_valid(resultValid[3]), .result_ready(resultReady[3]),
    .result_hit(resultHit[3]), .count_clear(countClear[3]), .hit_count(hitCountN));

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read ROMs: each instance sees the shared tables at its own address.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lowDout[k]  = {lowRom[1][bankAddr[k]], lowRom[0][bankAddr[k]]};
      highDout[k] = {highRom[1][bankAddr[k]], highRom[0][bankAddr[k]]};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] countObs(input int k);
    if (k == 3) return 32'(hitCountN);
    else        return 32'(hitCountW[k]);
  endfunction

  // Reference: search every populated table entry for the ID. With early exit
  // the sweep length is one past the lowest address that matched anywhere.
  function automatic void refQuery(input int k, input logic [15:0] id,
                                   output bit hit, output int n);
    int shortIdx;
    int firstA;
    int depth;
    shortIdx = (k == 1) ? -1 : 1;
    firstA   = -1;
    hit      = 1'b0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 2; b++) begin
        depth = (shortIdx >= 0 && b >= shortIdx) ? 3 : 4;
        if (a < depth && lowRom[b][a] <= id && id <= highRom[b][a]) begin
          hit = 1'b1;
          if (firstA < 0) firstA = a;
        end
      end
    end
    n = (k == 2 && hit) ? firstA + 1 : 4;
  endfunction

  // One complete query on instance k: accept, sweep, optional backpressure,
  // optional counter clear on the final sweep cycle, then the result handshake.
  task automatic applyStimulus(input int k, input logic [15:0] id,
                               input int holdCycles, input bit clearAtEnd);
    bit expHit;
    int expN;
    int waitCnt;
    bit gotValid;
    int maxCount;
    refQuery(k, id, expHit, expN);
    maxCount = (k == 3) ? 3 : 65535;
    idData[k]  = id;
    idValid[k] = 1'b1;
    waitCnt    = 0;
    while (!idReady[k] && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    checkOutput("accept_ready", 32'(idReady[k]), 32'd1);
    tick();
    idValid[k] = 1'b0;
    gotValid   = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (resultValid[k]) begin
        checkOutput("latency", 32'(cyc), 32'(expN + 1));
        gotValid = 1'b1;
        break;
      end
      checkOutput("scan_addr", 32'(bankAddr[k]), 32'(cyc - 1));
      checkOutput("scan_id_ready", 32'(idReady[k]), 32'd0);
      if (clearAtEnd && cyc == expN) countClear[k] = 1'b1;
      tick();
      countClear[k] = 1'b0;
    end
    checkOutput("result_seen", 32'(gotValid), 32'd1);
    if (clearAtEnd) modelCount[k] = 0;
    if (expHit && modelCount[k] < maxCount) modelCount[k]++;
    checkOutput("result_hit", 32'(resultHit[k]), 32'(expHit));
    checkOutput("done_addr", 32'(bankAddr[k]), 32'd0);
    checkOutput("hit_count", countObs(k), 32'(modelCount[k]));
    for (int h = 0; h < holdCycles; h++) begin
      tick();
      checkOutput("hold_valid", 32'(resultValid[k]), 32'd1);
      checkOutput("hold_hit", 32'(resultHit[k]), 32'(expHit));
      checkOutput("hold_id_ready", 32'(idReady[k]), 32'd0);
    end
    resultReady[k] = 1'b1;
    tick();
    resultReady[k] = 1'b0;
    checkOutput("post_valid", 32'(resultValid[k]), 32'd0);
    checkOutput("post_id_ready", 32'(idReady[k]), 32'd1);
  endtask

  task automatic loadDirectedRom();
    lowRom[0]  = '{16'd10, 16'd30, 16'd50, 16'd70};
    highRom[0] = '{16'd15, 16'd35, 16'd55, 16'd75};
    lowRom[1]  = '{16'd100, 16'd200, 16'd300, 16'd0};
    highRom[1] = '{16'd110, 16'd210, 16'd310, 16'hFFFF};
  endtask

  task automatic loadRandomRom();
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 4; a++) begin
        lowRom[b][a] = 16'($urandom_range(0, 200));
        if ($urandom_range(0, 4) == 0 && lowRom[b][a] > 0)
          highRom[b][a] = lowRom[b][a] - 16'd1;
        else
          highRom[b][a] = lowRom[b][a] + 16'($urandom_range(0, 20));
      end
    end
  endtask

  // Directed steps first, then randomized tables and IDs on every instance.
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idValid[k]     = 1'b0;
      idData[k]      = '0;
      resultReady[k] = 1'b0;
      countClear[k]  = 1'b0;
      modelCount[k]  = 0;
    end
    loadDirectedRom();

    tick();
    tick();
    checkOutput("rst_id_ready", 32'(idReady[0]), 32'd0);
    checkOutput("rst_bank_addr", 32'(bankAddr[0]), 32'd0);
    checkOutput("rst_result_valid", 32'(resultValid[0]), 32'd0);
    checkOutput("rst_result_hit", 32'(resultHit[0]), 32'd0);
    checkOutput("rst_hit_count", countObs(0), 32'd0);
    checkOutput("rst_hit_count_narrow", countObs(3), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_id_ready", 32'(idReady[0]), 32'd1);

    applyStimulus(0, 16'd15, 0, 1'b0);
    applyStimulus(0, 16'd100, 0, 1'b0);
    applyStimulus(0, 16'd16, 0, 1'b0);
    applyStimulus(0, 16'd310, 0, 1'b0);
    applyStimulus(0, 16'd5, 0, 1'b0);
    applyStimulus(1, 16'd5, 0, 1'b0);
    applyStimulus(2, 16'd32, 0, 1'b0);
    applyStimulus(0, 16'd15, 10, 1'b0);
    applyStimulus(0, 16'd12, 0, 1'b0);
    applyStimulus(0, 16'd40, 0, 1'b0);
    applyStimulus(0, 16'd205, 0, 1'b0);
    applyStimulus(3, 16'd15, 0, 1'b0);
    applyStimulus(3, 16'd100, 0, 1'b0);
    applyStimulus(3, 16'd310, 0, 1'b0);
    applyStimulus(3, 16'd12, 0, 1'b0);
    applyStimulus(3, 16'd205, 0, 1'b0);
    applyStimulus(0, 16'd72, 0, 1'b1);

    // Reset while instance 0 is sweeping address 2.
    idData[0]  = 16'd15;
    idValid[0] = 1'b1;
    tick();
    idValid[0] = 1'b0;
    tick();
    tick();
    checkOutput("midscan_addr", 32'(bankAddr[0]), 32'd2);
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_bank_addr", 32'(bankAddr[0]), 32'd0);
    checkOutput("midrst_result_valid", 32'(resultValid[0]), 32'd0);
    checkOutput("midrst_hit_count", countObs(0), 32'd0);
    checkOutput("midrst_id_ready", 32'(idReady[0]), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) modelCount[k] = 0;
    tick();
    checkOutput("midrst_idle_ready", 32'(idReady[0]), 32'd1);
    applyStimulus(0, 16'd15, 0, 1'b0);

    for (int round = 0; round < 6; round++) begin
      loadRandomRom();
      for (int q = 0; q < 8; q++) begin
        applyStimulus(int'($urandom_range(0, 3)), 16'($urandom_range(0, 230)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/range_scan_ctrl.md
Name: range_scan_ctrl

Overview:
- Sequences the banked range-bound ROMs (one "low" and one "high" bank per index) to decide whether a queried ID falls in any stored inclusive range.
- Accepts one ID per transaction over valid/ready and sweeps a shared address across all banks in parallel.
- Masks the unused tail entry of the short banks, returns a hit/miss result over valid/ready, and keeps a running count of hits.
- Sits between the ID input stream and the range ROM array.

Parameters:
- NUM_BANKS, 4: number of low/high bank pairs driven in parallel.
- MEM_LENGTH, 64: entries in a full-length bank.
- SHORT_INDEX, -1: first bank index holding MEM_LENGTH-1 entries. Negative means all banks are full length.
- ADDR_WIDTH, 6: width of the shared bank address, at least clog2(MEM_LENGTH).
- DATA_WIDTH, 64: width of IDs and bounds.
- COUNT_WIDTH, 16: width of the hit counter.
- EARLY_EXIT, 1: if 1, the sweep ends on the first hit; if 0, it always sweeps the full length.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  query ID offered
- id_ready  out  1  block can accept a query
- id_data  in  DATA_WIDTH  query ID
- bank_addr  out  ADDR_WIDTH  shared address to all low/high banks
- low_dout  in  NUM_BANKS*DATA_WIDTH  low-bank read data, bank i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- high_dout  in  NUM_BANKS*DATA_WIDTH  high-bank read data, same packing
- result_valid  out  1  result available
- result_ready  in  1  consumer takes result
- result_hit  out  1  1 when the ID lies in at least one range
- count_clear  in  1  clear the hit counter
- hit_count  out  COUNT_WIDTH  number of hit results produced

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low.
- Reset values: state IDLE, bank_addr 0, result_valid 0, result_hit 0, hit_count 0, latched ID 0. id_ready is 0 while rst_n is low.
- Banks are combinational read. Data for bank_addr is valid in the same cycle.
- Bank depth: bank i has depth MEM_LENGTH-1 if SHORT_INDEX >= 0 and i >= SHORT_INDEX; otherwise MEM_LENGTH.
- Bank i contributes at address a only when a < depth(i). Otherwise its data is ignored, whatever its value.
- Match rule: low <= id <= high, unsigned, inclusive at both ends. A range with low > high never matches.
- FSM IDLE:
  - id_ready = 1.
  - On id_valid: latch id_data, clear the hit accumulator, set bank_addr 0, go to SCAN.
- FSM SCAN:
  - id_ready = 0.
  - Each cycle: hit_now = OR over valid banks of the match at bank_addr; accumulator |= hit_now.
  - If bank_addr == MEM_LENGTH-1, or (EARLY_EXIT and hit_now): go to DONE, set result_valid 1, result_hit = accumulator | hit_now, bank_addr 0.
  - Otherwise bank_addr increments.
- FSM DONE:
  - result_valid = 1. result_hit is held stable until result_ready.
  - On result_ready: result_valid 0, go to IDLE.
  - The next ID is accepted at the earliest one cycle after the result handshake; there is no accept in the same cycle.
- Latency, taking the accept cycle as cycle 0:
  - SCAN occupies cycles 1..N, where N = MEM_LENGTH, or a+1 for an early exit at address a.
  - result_valid is high from cycle N+1.
- bank_addr is 0 in IDLE and DONE.
- hit_count:
  - Increments by 1 on the SCAN-to-DONE transition when result_hit will be 1.
  - Saturates at all-ones.
  - count_clear forces it to 0. If clear and increment occur in the same cycle, the result is 1.
- Backpressure: result_ready held low keeps the block in DONE indefinitely, with id_ready 0 and outputs stable.
- Reset mid-operation: rst_n low in any state returns all registers to reset values next edge. Any in-flight result is discarded and not counted.
- Sweep rule: no address >= MEM_LENGTH is ever driven.

Test Plan:
Common configuration: NUM_BANKS=2, MEM_LENGTH=4, SHORT_INDEX=1, DATA_WIDTH=16, EARLY_EXIT=0.
- Bank0 lows {10,30,50,70}, highs {15,35,55,75}.
- Bank1 lows {100,200,300,0}, highs {110,210,310,FFFF}.

Scenarios:
- Boundary hit: ID 15 -> result_hit=1; result_valid rises in cycle 5 after the accept; bank_addr sequence 0,1,2,3. ID 100 -> result_hit=1. ID 16 -> result_hit=0. ID 310 -> result_hit=1.
- Short-bank masking: ID 5 -> result_hit=0, even though bank1 entry 3 spans 0..FFFF. Change SHORT_INDEX to -1 and rerun -> result_hit=1.
- Early exit: EARLY_EXIT=1, ID 32 -> hit at address 1; result_valid in cycle 3; bank_addr never reaches 2.
- Backpressure and ordering:
  - Hold result_ready=0 for 10 cycles -> result_valid and result_hit stay stable and id_ready stays 0.
  - Release -> id_ready=1 the following cycle.
  - Back-to-back IDs 12, 40, 205 -> hits 1, 0, 1 in order; hit_count=2.
- Counter:
  - COUNT_WIDTH=2 with 5 hitting IDs -> hit_count saturates at 3.
  - count_clear asserted on the same cycle as a hit's SCAN-to-DONE transition -> hit_count=1.
- Reset mid-scan: rst_n low during SCAN at address 2 -> next cycle state IDLE, bank_addr 0, result_valid 0, hit_count unchanged at its reset value 0. The next query runs normally.
